// File: rtl/seg7_frame_monitor.sv
// Watches a seven-segment display bus and turns each newly settled pattern into a
// frame record: decoded glyph, cycles since the previous frame, first-frame flag.
module seg7_frame_monitor #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned PERIOD_W      = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg_in,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [4:0]          out_code,
  output logic [PERIOD_W-1:0] out_period,
  output logic                out_first,
  output logic                overrun,
  output logic [7:0]          frame_count
);

  localparam logic [15:0] STABLE_MAX = 16'(STABLE_CYCLES - 1);

  logic [6:0]          r_sync1;
  logic [6:0]          r_sync2;
  logic [6:0]          r_candidate;
  logic [6:0]          r_accepted;
  logic [15:0]         r_stableCnt;
  logic [PERIOD_W-1:0] r_periodCnt;
  logic                r_firstFlag;

  logic                w_event;
  logic                w_load;
  logic [4:0]          w_code;
  logic [PERIOD_W-1:0] w_periodInc;

  // A frame is a pattern that has held for the full window and differs from the last frame.
  assign w_event = (r_sync2 == r_candidate) && (r_stableCnt == STABLE_MAX) &&
                   (r_candidate != r_accepted);
  assign w_load  = w_event && (!out_valid || out_ready);

  // The captured period counts the event edge itself, so frames N cycles apart report N.
  assign w_periodInc = (&r_periodCnt) ? r_periodCnt : r_periodCnt + 1'b1;

  always_comb begin
    w_code = 5'h1F;
    case (r_candidate)
      7'h3F: w_code = 5'h00;
      7'h06: w_code = 5'h01;
      7'h5B: w_code = 5'h02;
      7'h4F: w_code = 5'h03;
      7'h66: w_code = 5'h04;
      7'h6D: w_code = 5'h05;
      7'h7D: w_code = 5'h06;
      7'h07: w_code = 5'h07;
      7'h7F: w_code = 5'h08;
      7'h6F: w_code = 5'h09;
      7'h77: w_code = 5'h0A;
      7'h7C: w_code = 5'h0B;
      7'h39: w_code = 5'h0C;
      7'h5E: w_code = 5'h0D;
      7'h79: w_code = 5'h0E;
      7'h71: w_code = 5'h0F;
      7'h00: w_code = 5'h10;
      default: w_code = 5'h1F;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 7'h00;
      r_sync2     <= 7'h00;
      r_candidate <= 7'h00;
      r_stableCnt <= 16'd0;
    end else begin
      r_sync1 <= seg_in;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_candidate) begin
        r_candidate <= r_sync2;
        r_stableCnt <= 16'd0;
      end else if (r_stableCnt != STABLE_MAX) begin
        r_stableCnt <= r_stableCnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_accepted  <= 7'h00;
      r_periodCnt <= '0;
      r_firstFlag <= 1'b1;
      frame_count <= 8'd0;
      overrun     <= 1'b0;
    end else begin
      if (w_event) begin
        r_accepted  <= r_candidate;
        r_periodCnt <= '0;
        r_firstFlag <= 1'b0;
        frame_count <= frame_count + 8'd1;
        if (!w_load) begin
          overrun <= 1'b1;
        end
      end else begin
        r_periodCnt <= w_periodInc;
      end
    end
  end

  // Single-entry output register; a frame arriving while it is still held is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_code   <= 5'h00;
      out_period <= '0;
      out_first  <= 1'b0;
    end else if (w_load) begin
      out_valid  <= 1'b1;
      out_code   <= w_code;
      out_period <= r_firstFlag ? '0 : w_periodInc;
      out_first  <= r_firstFlag;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_frame_monitor.sv
// Scoreboard bench for seg7_frame_monitor: each settled pattern that should produce a
// frame pushes an expected record; the monitor pops and compares on every handshake.
module tb_seg7_frame_monitor;

  localparam int S  = 16;
  localparam int PW = 12;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk;
  logic          rst_n;
  logic [6:0]    seg_in;
  logic          out_ready;
  logic          out_valid;
  logic [4:0]    out_code;
  logic [PW-1:0] out_period;
  logic          out_first;
  logic          overrun;
  logic [7:0]    frame_count;

  typedef struct {
    logic [4:0]  code;
    logic [31:0] period;
    logic        first;
    int          cycle;
    logic        checkLat;
  } recT;

  recT  expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   cycleCount = 0;

  logic [6:0] mAccepted;
  logic       mFirst;
  logic       mHolding;
  logic       mOverrun;
  int         mCount;
  int         mLastEvt;

  logic [6:0] digitPat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_frame_monitor #(.STABLE_CYCLES(S), .PERIOD_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .out_ready(out_ready),
    .out_valid(out_valid), .out_code(out_code), .out_period(out_period),
    .out_first(out_first), .overrun(overrun), .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [4:0] modelDecode(input logic [6:0] p);
    logic [4:0] r;
    r = (p == 7'h00) ? 5'h10 : 5'h1F;
    for (int i = 0; i < 16; i++) begin
      if (digitPat[i] == p) r = 5'(i);
    end
    return r;
  endfunction

  task automatic waitCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic modelReset();
    mAccepted = 7'h00;
    mFirst    = 1'b1;
    mHolding  = 1'b0;
    mOverrun  = 1'b0;
    mCount    = 0;
    mLastEvt  = 0;
  endtask

  // Drives a pattern and holds it; predicts whether and when it becomes a frame.
  task automatic applyStimulus(input logic [6:0] pat, input int hold);
    recT rec;
    int  evt;
    int  diff;
    seg_in = pat;
    if (pat != mAccepted && hold >= S + 3) begin
      evt  = cycleCount + S + 3;
      diff = evt - mLastEvt;
      rec.code     = modelDecode(pat);
      rec.first    = mFirst;
      rec.period   = mFirst ? 32'd0 : ((diff > PMAX) ? 32'(PMAX) : 32'(diff));
      rec.cycle    = evt;
      rec.checkLat = out_ready;
      if (mHolding) begin
        mOverrun = 1'b1;
      end else begin
        expQ.push_back(rec);
        if (!out_ready) mHolding = 1'b1;
      end
      mFirst    = 1'b0;
      mAccepted = pat;
      mLastEvt  = evt;
      mCount++;
    end
    repeat (hold) waitCycle();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"},  32'(out_valid),   32'd0);
    checkOutput({tag, "_code"},   32'(out_code),    32'd0);
    checkOutput({tag, "_period"}, 32'(out_period),  32'd0);
    checkOutput({tag, "_first"},  32'(out_first),   32'd0);
    checkOutput({tag, "_overrun"},32'(overrun),     32'd0);
    checkOutput({tag, "_count"},  32'(frame_count), 32'd0);
  endtask

  always @(negedge clk) begin
    recT exp;
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_record", 32'd1, 32'd0);
      end else begin
        exp = expQ.pop_front();
        checkOutput("rec_code",   32'(out_code),   32'(exp.code));
        checkOutput("rec_period", 32'(out_period), exp.period);
        checkOutput("rec_first",  32'(out_first),  32'(exp.first));
        if (exp.checkLat) checkOutput("rec_latency", 32'(cycleCount), 32'(exp.cycle));
      end
    end
  end

  initial begin
    int waited;
    rst_n     = 1'b0;
    seg_in    = 7'h00;
    out_ready = 1'b1;
    modelReset();
    repeat (3) waitCycle();
    checkResetState("reset");
    rst_n = 1'b1;

    // Basic frame, latency and first flag.
    applyStimulus(7'h06, 30);
    checkOutput("count_after_first", 32'(frame_count), 32'(mCount));

    // Short glitch then return to the accepted pattern: nothing fires.
    applyStimulus(7'h5B, 10);
    applyStimulus(7'h06, 40);
    checkOutput("count_after_glitch", 32'(frame_count), 32'd1);

    // Period measurement between frames 1000 cycles apart.
    applyStimulus(7'h3F, 1000);
    applyStimulus(7'h4F, 40);

    // Decoder: unknown, blank, letters and another unknown.
    applyStimulus(7'h01, 40);
    applyStimulus(7'h00, 40);
    applyStimulus(7'h77, 30);
    applyStimulus(7'h7C, 30);
    applyStimulus(7'h79, 30);
    applyStimulus(7'h71, 30);
    applyStimulus(7'h6F, 30);
    applyStimulus(7'h63, 30);

    // Backpressure: first record held, later ones dropped.
    out_ready = 1'b0;
    applyStimulus(7'h06, 100);
    applyStimulus(7'h5B, 100);
    applyStimulus(7'h66, 100);
    checkOutput("bp_valid",   32'(out_valid), 32'd1);
    checkOutput("bp_code",    32'(out_code),  32'(modelDecode(7'h06)));
    checkOutput("bp_overrun", 32'(overrun),   32'(mOverrun));
    checkOutput("bp_count",   32'(frame_count), 32'(mCount));
    out_ready = 1'b1;
    mHolding  = 1'b0;
    waitCycle();
    checkOutput("bp_release_valid", 32'(out_valid), 32'd0);

    // Period saturation after a long quiet stretch.
    applyStimulus(7'h3F, PMAX + 100);
    applyStimulus(7'h06, 30);

    // Frame counter wraps past 0xFF.
    for (int i = 0; i < 260; i++) begin
      applyStimulus((i % 2 == 0) ? 7'h3F : 7'h06, 20);
    end
    checkOutput("count_wrap", 32'(frame_count), 32'(mCount % 256));
    checkOutput("overrun_sticky", 32'(overrun), 32'(mOverrun));

    // Reset in the middle of filtering discards the pending pattern.
    checkOutput("queue_before_reset", 32'(expQ.size()), 32'd0);
    seg_in = 7'h7F;
    repeat (8) waitCycle();
    rst_n  = 1'b0;
    seg_in = 7'h00;
    modelReset();
    #1;
    checkResetState("midreset");
    repeat (2) waitCycle();
    rst_n = 1'b1;
    applyStimulus(7'h00, 40);
    checkOutput("blank_after_reset", 32'(frame_count), 32'd0);
    applyStimulus(7'h06, 30);
    checkOutput("count_after_reset", 32'(frame_count), 32'd1);

    waited = 0;
    while (expQ.size() != 0 && waited < 50) begin
      waitCycle();
      waited++;
    end
    checkOutput("drain", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
